// File: rtl/set_button_sequencer.sv
// set_button_sequencer
// Front end for hh:mm setting on the cuckoo clock board. The raw active-low
// setH/setM buttons are synchronised, debounced against the 4 ms tick, and
// fed to a press / hold / auto-repeat state machine. The FSM steers
// single-cycle increment pulses to the clock counter (displayMode = 1) or
// the alarm register (displayMode = 0). The target is latched when the
// press is first seen.
//
// Ports
//   sysclk       in   system clock (only clock)
//   reset        in   asynchronous, active-high reset
//   tick         in   one-cycle strobe every 4 ms; all timing counts these
//   setH, setM   in   raw buttons, active-low, asynchronous to sysclk
//   displayMode  in   1 = clock target, 0 = alarm target
//   cIncH/cIncM  out  one-cycle pulse: increment clock hours / minutes
//   aIncH/aIncM  out  one-cycle pulse: increment alarm hours / minutes
//   isSetting    out  high while editing, plus a holdoff after release
//   dbgState     out  current FSM state, for observation only
//
// Handshake: there is none. Each Inc output is a registered strobe that is
// exactly one sysclk wide. At most one of the four is high in any cycle,
// and the consumer must act on every cycle in which its strobe is high.
module set_button_sequencer #(
  parameter int DEBOUNCE_TICKS = 5,
  parameter int REPEAT_DELAY   = 125,
  parameter int REPEAT_PERIOD  = 50,
  parameter int HOLDOFF_TICKS  = 250
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       tick,
  input  logic       setH,
  input  logic       setM,
  input  logic       displayMode,
  output logic       cIncH,
  output logic       cIncM,
  output logic       aIncH,
  output logic       aIncM,
  output logic       isSetting,
  output logic [2:0] dbgState
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FIRST  = 3'd1;
  localparam logic [2:0] HOLD   = 3'd2;
  localparam logic [2:0] REPEAT = 3'd3;
  localparam logic [2:0] BLOCK  = 3'd4;

  localparam logic [7:0] DB_T  = 8'(DEBOUNCE_TICKS);
  localparam logic [7:0] RD_T  = 8'(REPEAT_DELAY);
  localparam logic [7:0] RP_T  = 8'(REPEAT_PERIOD);
  localparam logic [7:0] HO_T  = 8'(HOLDOFF_TICKS);

  // Bit 1 = hour button, bit 0 = minute button.
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      db_q, db_d;
  logic [1:0][7:0] dcnt_q, dcnt_d;

  logic [2:0] state_q, state_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic [7:0] hold_q, hold_d;
  logic       tgt_q, tgt_d;   // 1 = clock, 0 = alarm
  logic       sel_q, sel_d;   // 1 = hours, 0 = minutes
  logic [3:0] inc_q, inc_d;   // {cIncH, cIncM, aIncH, aIncM}
  logic [1:0] press;
  logic [3:0] sel_mask;

  // Debouncer: a level has to differ from the debounced state for
  // DEBOUNCE_TICKS consecutive ticks. Any return to agreement restarts it.
  always_comb begin
    db_d   = db_q;
    dcnt_d = dcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        dcnt_d[i] = 8'd0;
      end else if (tick) begin
        if (dcnt_q[i] + 8'd1 == DB_T) begin
          db_d[i]   = sync2_q[i];
          dcnt_d[i] = 8'd0;
        end else begin
          dcnt_d[i] = dcnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign press    = ~db_q;
  assign sel_mask = {tgt_q & sel_q, tgt_q & ~sel_q, ~tgt_q & sel_q, ~tgt_q & ~sel_q};

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    tgt_d   = tgt_q;
    sel_d   = sel_q;
    inc_d   = 4'b0000;
    case (state_q)
      IDLE: begin
        tcnt_d = 8'd0;
        if (press == 2'b10 || press == 2'b01) begin
          tgt_d   = displayMode;
          sel_d   = press[1];
          state_d = FIRST;
        end else if (press == 2'b11) begin
          state_d = BLOCK;
        end
      end
      FIRST: begin
        inc_d   = sel_mask;
        tcnt_d  = 8'd0;
        state_d = HOLD;
      end
      HOLD, REPEAT: begin
        // Exits take priority; a tick landing on a transition is dropped.
        if (press == 2'b00) begin
          state_d = IDLE;
          tcnt_d  = 8'd0;
        end else if (press == 2'b11) begin
          state_d = BLOCK;
          tcnt_d  = 8'd0;
        end else if (tick) begin
          if (tcnt_q + 8'd1 == ((state_q == HOLD) ? RD_T : RP_T)) begin
            tcnt_d = 8'd0;
            if (state_q == HOLD) state_d = REPEAT;
            else                 inc_d   = sel_mask;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
      end
      BLOCK: begin
        tcnt_d = 8'd0;
        if (press == 2'b00) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        tcnt_d  = 8'd0;
      end
    endcase
  end

  // Holdoff reloads on every entry to IDLE and only runs while idle.
  always_comb begin
    hold_d = hold_q;
    if (state_q != IDLE && state_d == IDLE)     hold_d = HO_T;
    else if (state_d != IDLE)                   hold_d = 8'd0;
    else if (tick && hold_q != 8'd0)            hold_d = hold_q - 8'd1;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      db_q    <= 2'b11;
      dcnt_q  <= '0;
      state_q <= IDLE;
      tcnt_q  <= 8'd0;
      hold_q  <= 8'd0;
      tgt_q   <= 1'b0;
      sel_q   <= 1'b0;
      inc_q   <= 4'b0000;
    end else begin
      sync1_q <= {setH, setM};
      sync2_q <= sync1_q;
      db_q    <= db_d;
      dcnt_q  <= dcnt_d;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      hold_q  <= hold_d;
      tgt_q   <= tgt_d;
      sel_q   <= sel_d;
      inc_q   <= inc_d;
    end
  end

  assign {cIncH, cIncM, aIncH, aIncM} = inc_q;
  assign isSetting = (state_q != IDLE) || (hold_q != 8'd0);
  assign dbgState  = state_q;

endmodule

// File: tb/tb_set_button_sequencer.sv
module tb_set_button_sequencer;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic       tick   = 1'b0;
  logic       setH   = 1'b1;
  logic       setM   = 1'b1;
  logic       displayMode = 1'b1;
  logic       cIncH, cIncM, aIncH, aIncM, isSetting;
  logic [2:0] dbgState;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REPEAT = 3'd3;
  localparam logic [2:0] S_BLOCK  = 3'd4;
  localparam logic [3:0] P_CH = 4'b1000;
  localparam logic [3:0] P_CM = 4'b0100;
  localparam logic [3:0] P_AM = 4'b0001;

  set_button_sequencer dut (
    .sysclk(sysclk), .reset(reset), .tick(tick), .setH(setH), .setM(setM),
    .displayMode(displayMode), .cIncH(cIncH), .cIncM(cIncM), .aIncH(aIncH),
    .aIncM(aIncM), .isSetting(isSetting), .dbgState(dbgState)
  );

  // clock / reset / tick
  always #5 sysclk = ~sysclk;

  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge sysclk);
      div  = (div + 1) % 4;
      tick = (div == 0);
    end
  end

  // scoreboard state
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] exp_q[$];
  int         tick_cnt  = 0;
  int         pulse_cnt = 0;
  int         stamps[64];
  logic [3:0] prev_inc  = 4'b0;
  logic       prev_set  = 1'b0;
  logic [2:0] prev_state = 3'd0;
  logic       seen_set  = 1'b0;
  logic       fall_seen = 1'b0;
  int         idle_stamp = 0;
  int         fall_stamp = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // monitor: pops one expected pulse for every pulse the DUT emits
  always @(posedge sysclk) begin
    logic [3:0] inc;
    logic [3:0] e;
    #1;
    if (tick) tick_cnt++;
    inc = {cIncH, cIncM, aIncH, aIncM};
    if (inc != 4'b0) begin
      check("one_hot", $countones(inc), 1);
      check("pulse_width", {28'd0, prev_inc}, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {28'd0, inc}, 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_target", {28'd0, inc}, {28'd0, e});
      end
      if (pulse_cnt < 64) stamps[pulse_cnt] = tick_cnt;
      pulse_cnt++;
    end
    if (isSetting) seen_set = 1'b1;
    if (prev_set && !isSetting) begin
      fall_seen  = 1'b1;
      fall_stamp = tick_cnt;
    end
    if (prev_state != S_IDLE && dbgState == S_IDLE) idle_stamp = tick_cnt;
    prev_inc   = inc;
    prev_set   = isSetting;
    prev_state = dbgState;
  end

  // driver tasks
  task automatic wait_ticks(input int n);
    int tgt;
    tgt = tick_cnt + n;
    while (tick_cnt < tgt) @(negedge sysclk);
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (dbgState == st) break;
      @(negedge sysclk);
    end
    check(tag, {29'd0, dbgState}, {29'd0, st});
  endtask

  task automatic wait_pulses(input int target, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (pulse_cnt >= target) break;
      @(negedge sysclk);
    end
    check(tag, pulse_cnt, target);
  endtask

  task automatic check_latency(input string tag, input int t0, input int idx);
    int d;
    d = stamps[idx] - t0;
    check(tag, (d >= 5 && d <= 6) ? 1 : 0, 1);
  endtask

  initial begin
    int t0;
    int base;

    // reset state
    repeat (3) @(negedge sysclk);
    #1;
    check("reset_inc", {28'd0, cIncH, cIncM, aIncH, aIncM}, 0);
    check("reset_isSetting", {31'd0, isSetting}, 0);
    check("reset_state", {29'd0, dbgState}, S_IDLE);
    @(negedge sysclk);
    reset = 1'b0;
    wait_ticks(2);

    // bounce shorter than the debounce window
    seen_set = 1'b0;
    setM = 1'b0;
    wait_ticks(3);
    setM = 1'b1;
    wait_ticks(10);
    check("bounce_isSetting", {31'd0, seen_set}, 0);
    check("bounce_pulses", pulse_cnt, 0);

    // single press to clock hours, holdoff timing
    displayMode = 1'b1;
    base = pulse_cnt;
    exp_q.push_back(P_CH);
    t0 = tick_cnt;
    setH = 1'b0;
    wait_ticks(10);
    check("single_count", pulse_cnt, base + 1);
    check_latency("single_latency", t0, base);
    fall_seen = 1'b0;
    setH = 1'b1;
    wait_state(S_IDLE, 100, "single_idle");
    check("holdoff_high", {31'd0, isSetting}, 1);
    for (int i = 0; i < 1200; i++) begin
      if (fall_seen) break;
      @(negedge sysclk);
    end
    check("holdoff_fall_seen", {31'd0, fall_seen}, 1);
    check("holdoff_ticks", fall_stamp - idle_stamp, 250);

    // alarm minutes with auto-repeat
    displayMode = 1'b0;
    base = pulse_cnt;
    repeat (4) exp_q.push_back(P_AM);
    t0 = tick_cnt;
    setM = 1'b0;
    wait_ticks(5 + 125 + 3 * 50);
    setM = 1'b1;
    wait_pulses(base + 4, 200, "repeat_count");
    wait_state(S_IDLE, 100, "repeat_idle");
    check("repeat_total", pulse_cnt, base + 4);
    check_latency("repeat_latency", t0, base);
    check("repeat_delay", stamps[base + 1] - stamps[base], 175);
    check("repeat_period1", stamps[base + 2] - stamps[base + 1], 50);
    check("repeat_period2", stamps[base + 3] - stamps[base + 2], 50);

    // displayMode change mid-hold does not redirect
    displayMode = 1'b1;
    base = pulse_cnt;
    repeat (2) exp_q.push_back(P_CH);
    t0 = tick_cnt;
    setH = 1'b0;
    wait_pulses(base + 1, 100, "latch_first");
    displayMode = 1'b0;
    while (tick_cnt < t0 + 190) @(negedge sysclk);
    setH = 1'b1;
    wait_state(S_IDLE, 100, "latch_idle");
    check("latch_total", pulse_cnt, base + 2);

    // second button mid-hold -> BLOCK
    displayMode = 1'b1;
    base = pulse_cnt;
    exp_q.push_back(P_CH);
    setH = 1'b0;
    wait_ticks(20);
    setM = 1'b0;
    wait_ticks(30);
    check("block_both", {29'd0, dbgState}, S_BLOCK);
    setH = 1'b1;
    wait_ticks(20);
    check("block_one_left", {29'd0, dbgState}, S_BLOCK);
    setM = 1'b1;
    wait_state(S_IDLE, 100, "block_exit");
    check("block_total", pulse_cnt, base + 1);
    exp_q.push_back(P_CM);
    setM = 1'b0;
    wait_ticks(10);
    setM = 1'b1;
    wait_state(S_IDLE, 100, "fresh_idle");
    check("fresh_total", pulse_cnt, base + 2);

    // reset during REPEAT with the button still held
    displayMode = 1'b0;
    base = pulse_cnt;
    exp_q.push_back(P_AM);
    setM = 1'b0;
    wait_state(S_REPEAT, 1000, "rst_reach_repeat");
    wait_ticks(5);
    reset = 1'b1;
    #1;
    check("rst_async_inc", {28'd0, cIncH, cIncM, aIncH, aIncM}, 0);
    check("rst_async_isSetting", {31'd0, isSetting}, 0);
    check("rst_async_state", {29'd0, dbgState}, S_IDLE);
    repeat (3) @(negedge sysclk);
    check("rst_no_pulse", pulse_cnt, base + 1);
    exp_q.push_back(P_AM);
    t0 = tick_cnt;
    reset = 1'b0;
    wait_pulses(base + 2, 100, "rst_repress");
    check_latency("rst_latency", t0, base + 1);
    setM = 1'b1;
    wait_state(S_IDLE, 100, "rst_idle");

    wait_ticks(5);
    check("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
